// File: rtl/decode_pkg.sv
// Shared types and constants for the decode-and-hold block and its hold counter.
package decode_pkg;

  localparam int HOLD_MAX = 15;
  localparam int CNT_W    = 4;

  typedef enum logic {
    ST_IDLE,
    ST_HOLD
  } state_t;

endpackage

// File: rtl/hold_cnt.sv
// Loadable down-counter that stops at zero and reports when it is there.
module hold_cnt
  import decode_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  // clear beats load beats decrement; decrement is gated at zero so it never wraps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/decode_hold.sv
// Decodes a 2-bit line index into a one-hot output and holds it for HOLD cycles,
// accepting the next code back-to-back on the last hold cycle.
module decode_hold
  import decode_pkg::*;
#(
  parameter int HOLD = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] in_code,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       flush,
  output logic [3:0] out,
  output logic       out_valid,
  output logic       busy
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(HOLD - 1);

  state_t     state;
  state_t     state_next;
  logic [3:0] out_next;
  logic       accept;
  logic       cnt_zero;
  logic       cnt_dec;

  assign in_ready  = (state == ST_IDLE) || cnt_zero;
  assign accept    = in_valid && in_ready && !flush;
  assign out_valid = (out != 4'b0000);
  assign busy      = (state == ST_HOLD);

  hold_cnt u_hold_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (flush),
    .load     (accept),
    .load_val (RELOAD),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // flush wins over a same-cycle accept, so the offered code is simply dropped
  always_comb begin
    state_next = state;
    out_next   = out;
    cnt_dec    = (state == ST_HOLD) && !cnt_zero;
    if (flush) begin
      state_next = ST_IDLE;
      out_next   = 4'b0000;
    end else if (accept) begin
      state_next = ST_HOLD;
      out_next   = 4'b0001 << in_code;
    end else if ((state == ST_HOLD) && cnt_zero) begin
      state_next = ST_IDLE;
      out_next   = 4'b0000;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      out   <= 4'b0000;
    end else begin
      state <= state_next;
      out   <= out_next;
    end
  end

endmodule

// File: tb/tb_decode_hold.sv
// Scenario bench for decode_hold: one instance with HOLD=4 and one with HOLD=1.
module tb_decode_hold;

  typedef struct packed {
    logic [3:0] out;
    logic       ready;
    logic       busy;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] code4, code1;
  logic       valid4, valid1, flush4, flush1;
  logic       ready4, ready1, ovalid4, ovalid1, busy4, busy1;
  logic [3:0] out4, out1;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  decode_hold #(.HOLD(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_code(code4), .in_valid(valid4), .in_ready(ready4),
    .flush(flush4), .out(out4), .out_valid(ovalid4), .busy(busy4)
  );

  decode_hold #(.HOLD(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_code(code1), .in_valid(valid1), .in_ready(ready1),
    .flush(flush1), .out(out1), .out_valid(ovalid1), .busy(busy1)
  );

  task automatic test_reset();
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back('{4'b0000, 1'b1, 1'b0});
      if (i == 1) begin
        @(posedge clk);
        #1;
      end
      e = exp_q.pop_front();
      checks++; if (out4 !== e.out) begin errors++; $display("FAIL reset out4 step %0d: got %b want %b", i, out4, e.out); end
      checks++; if (ovalid4 !== (e.out != 4'b0)) begin errors++; $display("FAIL reset out_valid4 step %0d: got %b", i, ovalid4); end
      checks++; if (ready4 !== e.ready) begin errors++; $display("FAIL reset ready4 step %0d: got %b want %b", i, ready4, e.ready); end
      checks++; if (busy4 !== e.busy) begin errors++; $display("FAIL reset busy4 step %0d: got %b want %b", i, busy4, e.busy); end
      checks++; if (out1 !== e.out) begin errors++; $display("FAIL reset out1 step %0d: got %b want %b", i, out1, e.out); end
      checks++; if (ready1 !== e.ready) begin errors++; $display("FAIL reset ready1 step %0d: got %b want %b", i, ready1, e.ready); end
    end
    #2 rst_n = 1'b1;
  endtask

  task automatic test_single();
    exp_t e;
    exp_t t[6];
    t = '{'{4'b0100, 1'b0, 1'b1}, '{4'b0100, 1'b0, 1'b1}, '{4'b0100, 1'b0, 1'b1},
          '{4'b0100, 1'b1, 1'b1}, '{4'b0000, 1'b1, 1'b0}, '{4'b0000, 1'b1, 1'b0}};
    for (int i = 0; i < 6; i++) begin
      valid4 = (i == 0);
      code4  = 2'b10;
      exp_q.push_back(t[i]);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      checks++; if (out4 !== e.out) begin errors++; $display("FAIL single out step %0d: got %b want %b", i, out4, e.out); end
      checks++; if (ovalid4 !== (e.out != 4'b0)) begin errors++; $display("FAIL single out_valid step %0d: got %b", i, ovalid4); end
      checks++; if (ready4 !== e.ready) begin errors++; $display("FAIL single ready step %0d: got %b want %b", i, ready4, e.ready); end
      checks++; if (busy4 !== e.busy) begin errors++; $display("FAIL single busy step %0d: got %b want %b", i, busy4, e.busy); end
    end
  endtask

  task automatic test_back_to_back();
    exp_t       e;
    logic [3:0] eo;
    logic       er, eb;
    for (int i = 0; i < 18; i++) begin
      valid4 = (i < 16);
      code4  = 2'((i / 4) % 4);
      eo = (i < 16) ? (4'b0001 << (i / 4)) : 4'b0000;
      er = (i < 16) ? (((i + 1) % 4) == 0) : 1'b1;
      eb = (i < 16);
      exp_q.push_back('{eo, er, eb});
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      checks++; if (out4 !== e.out) begin errors++; $display("FAIL b2b out step %0d: got %b want %b", i, out4, e.out); end
      checks++; if (ovalid4 !== (e.out != 4'b0)) begin errors++; $display("FAIL b2b out_valid step %0d: got %b", i, ovalid4); end
      checks++; if (ready4 !== e.ready) begin errors++; $display("FAIL b2b ready step %0d: got %b want %b", i, ready4, e.ready); end
      checks++; if (busy4 !== e.busy) begin errors++; $display("FAIL b2b busy step %0d: got %b want %b", i, busy4, e.busy); end
    end
    valid4 = 1'b0;
  endtask

  task automatic test_flush();
    exp_t       e;
    logic       v[11], f[11], er[11], eb[11];
    logic [1:0] c[11];
    logic [3:0] eo[11];
    v  = '{1, 0, 1, 1, 0, 1, 0, 0, 0, 1, 0};
    c  = '{3, 0, 2, 1, 0, 0, 0, 0, 0, 2, 0};
    f  = '{0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 0};
    eo = '{8, 8, 0, 0, 0, 1, 1, 1, 1, 0, 0};
    er = '{0, 0, 1, 1, 1, 0, 0, 0, 1, 1, 1};
    eb = '{1, 1, 0, 0, 0, 1, 1, 1, 1, 0, 0};
    for (int i = 0; i < 11; i++) begin
      valid4 = v[i];
      code4  = c[i];
      flush4 = f[i];
      exp_q.push_back('{eo[i], er[i], eb[i]});
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      checks++; if (out4 !== e.out) begin errors++; $display("FAIL flush out step %0d: got %b want %b", i, out4, e.out); end
      checks++; if (ovalid4 !== (e.out != 4'b0)) begin errors++; $display("FAIL flush out_valid step %0d: got %b", i, ovalid4); end
      checks++; if (ready4 !== e.ready) begin errors++; $display("FAIL flush ready step %0d: got %b want %b", i, ready4, e.ready); end
      checks++; if (busy4 !== e.busy) begin errors++; $display("FAIL flush busy step %0d: got %b want %b", i, busy4, e.busy); end
    end
    flush4 = 1'b0;
    valid4 = 1'b0;
  endtask

  task automatic test_async_reset();
    exp_t e;
    valid4 = 1'b1;
    code4  = 2'b01;
    @(posedge clk);
    #1;
    valid4 = 1'b0;
    @(posedge clk);
    #1;
    exp_q.push_back('{4'b0010, 1'b0, 1'b1});
    exp_q.push_back('{4'b0000, 1'b1, 1'b0});
    exp_q.push_back('{4'b0000, 1'b1, 1'b0});
    exp_q.push_back('{4'b1000, 1'b0, 1'b1});
    exp_q.push_back('{4'b1000, 1'b0, 1'b1});
    exp_q.push_back('{4'b1000, 1'b0, 1'b1});
    exp_q.push_back('{4'b1000, 1'b1, 1'b1});
    exp_q.push_back('{4'b0000, 1'b1, 1'b0});
    for (int i = 0; i < 8; i++) begin
      if (i == 1) begin
        #2 rst_n = 1'b0;
        #1;
      end else if (i == 2) begin
        valid4 = 1'b1;
        code4  = 2'b11;
        @(posedge clk);
        #1;
      end else if (i == 3) begin
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        valid4 = 1'b0;
      end else if (i > 3) begin
        @(posedge clk);
        #1;
      end
      e = exp_q.pop_front();
      checks++; if (out4 !== e.out) begin errors++; $display("FAIL areset out step %0d: got %b want %b", i, out4, e.out); end
      checks++; if (ovalid4 !== (e.out != 4'b0)) begin errors++; $display("FAIL areset out_valid step %0d: got %b", i, ovalid4); end
      checks++; if (ready4 !== e.ready) begin errors++; $display("FAIL areset ready step %0d: got %b want %b", i, ready4, e.ready); end
      checks++; if (busy4 !== e.busy) begin errors++; $display("FAIL areset busy step %0d: got %b want %b", i, busy4, e.busy); end
    end
  endtask

  task automatic test_hold1();
    exp_t       e;
    logic       v[3];
    logic [1:0] c[3];
    exp_t       t[3];
    v = '{1, 1, 0};
    c = '{1, 3, 0};
    t = '{'{4'b0010, 1'b1, 1'b1}, '{4'b1000, 1'b1, 1'b1}, '{4'b0000, 1'b1, 1'b0}};
    checks++; if (ready1 !== 1'b1) begin errors++; $display("FAIL hold1 idle ready: got %b want 1", ready1); end
    for (int i = 0; i < 3; i++) begin
      valid1 = v[i];
      code1  = c[i];
      exp_q.push_back(t[i]);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      checks++; if (out1 !== e.out) begin errors++; $display("FAIL hold1 out step %0d: got %b want %b", i, out1, e.out); end
      checks++; if (ovalid1 !== (e.out != 4'b0)) begin errors++; $display("FAIL hold1 out_valid step %0d: got %b", i, ovalid1); end
      checks++; if (ready1 !== e.ready) begin errors++; $display("FAIL hold1 ready step %0d: got %b want %b", i, ready1, e.ready); end
      checks++; if (busy1 !== e.busy) begin errors++; $display("FAIL hold1 busy step %0d: got %b want %b", i, busy1, e.busy); end
    end
  endtask

  task automatic test_no_valid();
    exp_t       e;
    logic       v[9], er[9], eb[9];
    logic [1:0] c[9];
    logic [3:0] eo[9];
    v  = '{0, 0, 0, 0, 1, 1, 1, 0, 0};
    c  = '{0, 1, 2, 3, 2, 0, 3, 1, 1};
    eo = '{0, 0, 0, 0, 4, 4, 4, 4, 0};
    er = '{1, 1, 1, 1, 0, 0, 0, 1, 1};
    eb = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
    for (int i = 0; i < 9; i++) begin
      valid4 = v[i];
      code4  = c[i];
      exp_q.push_back('{eo[i], er[i], eb[i]});
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      checks++; if (out4 !== e.out) begin errors++; $display("FAIL novalid out step %0d: got %b want %b", i, out4, e.out); end
      checks++; if (ovalid4 !== (e.out != 4'b0)) begin errors++; $display("FAIL novalid out_valid step %0d: got %b", i, ovalid4); end
      checks++; if (ready4 !== e.ready) begin errors++; $display("FAIL novalid ready step %0d: got %b want %b", i, ready4, e.ready); end
      checks++; if (busy4 !== e.busy) begin errors++; $display("FAIL novalid busy step %0d: got %b want %b", i, busy4, e.busy); end
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    code4  = 2'b00;
    valid4 = 1'b0;
    flush4 = 1'b0;
    code1  = 2'b00;
    valid1 = 1'b0;
    flush1 = 1'b0;
    #2;
    test_reset();
    test_single();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_hold1();
    test_no_valid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
